// File: rtl/i2c_cmd_arbiter_pkg.sv
// Shared types for the I2C command arbiter: FSM states, the forwarded command
// record and a small index helper.
package package_i2c;

    localparam int I2C_BURST_WIDTH = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CMD,
        ARB_WDATA
    } t_arb_states;

    typedef struct packed {
        logic                       we;
        logic                       sccb_mode;
        logic [6:0]                 addr_slave;
        logic [7:0]                 addr_reg;
        logic [I2C_BURST_WIDTH-1:0] burst_num;
    } t_i2c_cmd;

    // Cyclic successor of a requester index.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_rr_pick.sv
// Combinational requester picker: first request at or after ptr_i (cyclic), or the
// lowest-index request when I2C_ARB_FIXED_PRIO_EN is defined (ptr_i is then ignored).
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int unsigned cand;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
`ifdef I2C_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end
        end
`else
        // Walk backwards so the closest request after ptr_i is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = (32'(ptr_i) + 32'(k)) % NUM_REQ;
            if (req_i[cand]) begin
                idx_o = IDX_W'(cand);
                any_o = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares the I2C manager command and write-byte ports between NUM_REQ requesters,
// holding the grant through a write burst. Define I2C_ARB_FIXED_PRIO_EN for fixed priority.
//
// state     | meaning
// ARB_IDLE  | no grantee; pick one from the pending requests
// ARB_CMD   | grantee's command is presented to the manager
// ARB_WDATA | grantee's write bytes are forwarded until the burst count reaches zero
module i2c_cmd_arbiter
    import package_i2c::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int BURST_WIDTH = I2C_BURST_WIDTH,
    localparam int GW         = $clog2(NUM_REQ)
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NUM_REQ-1:0]                i_req_valid,
    input  logic [NUM_REQ-1:0]                i_req_we,
    input  logic [NUM_REQ-1:0]                i_req_sccb_mode,
    input  logic [NUM_REQ-1:0][6:0]           i_req_addr_slave,
    input  logic [NUM_REQ-1:0][7:0]           i_req_addr_reg,
    input  logic [NUM_REQ-1:0][BURST_WIDTH-1:0] i_req_burst_num,
    output logic [NUM_REQ-1:0]                o_req_ready,
    input  logic [NUM_REQ-1:0]                i_wr_valid,
    input  logic [NUM_REQ-1:0][7:0]           i_wr_byte,
    output logic [NUM_REQ-1:0]                o_wr_ready,
    output logic                              o_valid,
    output logic                              o_we,
    output logic                              o_sccb_mode,
    output logic [6:0]                        o_addr_slave,
    output logic [7:0]                        o_addr_reg,
    output logic [BURST_WIDTH-1:0]            o_burst_num,
    input  logic                              i_ready,
    output logic                              o_valid_wr_byte,
    output logic [7:0]                        o_wr_byte,
    input  logic                              i_ready_wr_byte,
    output logic [GW-1:0]                     o_grant,
    output logic                              o_busy
);

    localparam logic [BURST_WIDTH:0] CNT_ONE = (BURST_WIDTH + 1)'(1);

    generate
        if (BURST_WIDTH != I2C_BURST_WIDTH) begin : g_bw_check
            $error("BURST_WIDTH must match I2C_BURST_WIDTH");
        end
    endgenerate

    t_arb_states          state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [BURST_WIDTH:0] wr_cnt_q, wr_cnt_d;
    logic [GW-1:0]        grant_next;
    logic [GW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 release_grant;
    logic [GW-1:0]        pick_ptr;
    t_i2c_cmd             cmd_sel;

    assign grant_next = GW'(wrap_inc(32'(grant_q), NUM_REQ));

`ifdef I2C_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    assign pick_ptr = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (release_grant) begin
            rr_ptr_d = grant_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (GW)
    ) u_pick (
        .req_i(i_req_valid),
        .ptr_i(pick_ptr),
        .idx_o(pick_idx),
        .any_o(pick_any)
    );

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        wr_cnt_d        = wr_cnt_q;
        release_grant   = 1'b0;
        cmd_sel         = '0;
        o_valid         = 1'b0;
        o_req_ready     = '0;
        o_valid_wr_byte = 1'b0;
        o_wr_byte       = '0;
        o_wr_ready      = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ARB_CMD;
                end
            end

            ARB_CMD: begin
                cmd_sel.we         = i_req_we[grant_q];
                cmd_sel.sccb_mode  = i_req_sccb_mode[grant_q];
                cmd_sel.addr_slave = i_req_addr_slave[grant_q];
                cmd_sel.addr_reg   = i_req_addr_reg[grant_q];
                cmd_sel.burst_num  = i_req_burst_num[grant_q];
                o_valid            = i_req_valid[grant_q];
                o_req_ready[grant_q] = i_req_valid[grant_q] & i_ready;
                if (i_req_valid[grant_q] && i_ready) begin
                    if (i_req_we[grant_q]) begin
                        // One extra bit so burst_num = all-ones still counts 2**BURST_WIDTH bytes.
                        wr_cnt_d = {1'b0, i_req_burst_num[grant_q]} + CNT_ONE;
                        state_d  = ARB_WDATA;
                    end else begin
                        release_grant = 1'b1;
                        state_d       = ARB_IDLE;
                    end
                end else if (!i_req_valid[grant_q]) begin
                    state_d = ARB_IDLE;
                end
            end

            ARB_WDATA: begin
                o_valid_wr_byte     = i_wr_valid[grant_q];
                o_wr_byte           = i_wr_byte[grant_q];
                o_wr_ready[grant_q] = i_wr_valid[grant_q] & i_ready_wr_byte;
                if (i_wr_valid[grant_q] && i_ready_wr_byte) begin
                    wr_cnt_d = wr_cnt_q - CNT_ONE;
                    if (wr_cnt_q == CNT_ONE) begin
                        release_grant = 1'b1;
                        state_d       = ARB_IDLE;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign o_we         = cmd_sel.we;
    assign o_sccb_mode  = cmd_sel.sccb_mode;
    assign o_addr_slave = cmd_sel.addr_slave;
    assign o_addr_reg   = cmd_sel.addr_reg;
    assign o_burst_num  = cmd_sel.burst_num;
    assign o_grant      = grant_q;
    assign o_busy       = (state_q != ARB_IDLE);

endmodule
